// File: rtl/vortex_mem_arbiter.sv
// Purpose : Share one 512-bit-line local-memory port between Vortex and AHB.
//           Vortex has priority. AHB is forced to win after MAX_AHB_WAIT denials.
// Latency : 1 cycle from grant to RAM. Vortex read response: grant+2 when the FIFO is empty.
//           AHB read: one stall cycle, then data.
// Backpr. : Vortex reads are admitted only while FIFO+in-flight has a free slot, so
//           mem_rsp_ready backpressure can never overflow the response FIFO.
//
// Ports   : clk/RST (sync, active-high); mem_req_* / mem_rsp_* Vortex line interface;
//           bp_* AHB word interface; ram_* single-port line memory (1-cycle read).

// Generic synchronous FIFO.
// Latency : 1 cycle (push visible at head the cycle after).
// Backpr. : none internally; the caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    push_vld,
    input  logic [WIDTH-1:0]        push_dat,
    input  logic                    pop_vld,
    output logic [WIDTH-1:0]        head_dat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_vld) - CW'(pop_vld);
        end
    end

    // Storage carries no reset; an empty FIFO is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module vortex_mem_arbiter #(
    parameter int LOCAL_MEM_SIZE = 15,
    parameter int VX_ADDR_WIDTH  = 26,
    parameter int VX_TAG_WIDTH   = 56,
    parameter int RSP_DEPTH      = 2,
    parameter int MAX_AHB_WAIT   = 4
) (
    input  logic                        clk,
    input  logic                        RST,
    // Vortex request
    input  logic                        mem_req_valid,
    input  logic                        mem_req_rw,
    input  logic [63:0]                 mem_req_byteen,
    input  logic [VX_ADDR_WIDTH-1:0]    mem_req_addr,
    input  logic [511:0]                mem_req_data,
    input  logic [VX_TAG_WIDTH-1:0]     mem_req_tag,
    output logic                        mem_req_ready,
    // Vortex response
    output logic                        mem_rsp_valid,
    output logic [511:0]                mem_rsp_data,
    output logic [VX_TAG_WIDTH-1:0]     mem_rsp_tag,
    input  logic                        mem_rsp_ready,
    // AHB generic bus peripheral
    input  logic                        bp_wen,
    input  logic                        bp_ren,
    input  logic [31:0]                 bp_addr,
    input  logic [31:0]                 bp_wdata,
    input  logic [3:0]                  bp_strobe,
    output logic [31:0]                 bp_rdata,
    output logic                        bp_request_stall,
    output logic                        bp_error,
    // Local memory port
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [LOCAL_MEM_SIZE-7:0]   ram_addr,
    output logic [63:0]                 ram_byteen,
    output logic [511:0]                ram_wdata,
    input  logic [511:0]                ram_rdata
);
    localparam int LW = LOCAL_MEM_SIZE - 6;
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int SW = $clog2(MAX_AHB_WAIT + 1);

    typedef enum logic [0:0] {IDLE, AHB_RD_WAIT} state_t;

    typedef struct packed {
        logic [511:0]             data;
        logic [VX_TAG_WIDTH-1:0]  tag;
    } rsp_t;

    state_t                 state_q, state_d;
    logic                   inflight_q;
    logic [VX_TAG_WIDTH-1:0] tag_q;
    logic [3:0]             lane_q;
    logic [SW-1:0]          starve_q;

    logic                   bp_any, addr_ok, ahb_req, vx_ok, ahb_gnt, vx_gnt;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          rsp_occ;
    rsp_t                   rsp_push, rsp_head;
    logic                   rsp_pop;

    // Address bits above the local memory and the byte-within-word bits are not decoded.
    logic unused_bits;
    assign unused_bits = &{1'b0, mem_req_addr[VX_ADDR_WIDTH-1:LW], bp_addr[1:0]};

    // ---------------- request qualification and grant ----------------
    assign bp_any  = bp_wen | bp_ren;
    assign addr_ok = (bp_addr[31:LOCAL_MEM_SIZE] == '0);
    assign ahb_req = bp_any & addr_ok & (state_q != AHB_RD_WAIT) & ~RST;

    // Count in-flight reads against FIFO space so a response always has a slot.
    assign rsp_occ = fifo_count + CW'(inflight_q);
    assign vx_ok   = mem_req_valid & (mem_req_rw | (rsp_occ < CW'(RSP_DEPTH))) & ~RST;

    assign ahb_gnt = ahb_req & (~vx_ok | (starve_q == SW'(MAX_AHB_WAIT)));
    assign vx_gnt  = vx_ok & ~ahb_gnt;

    assign mem_req_ready = vx_gnt;

    // ---------------- FSM next state and RAM port ----------------
    always_comb begin
        state_d    = state_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_byteen = '0;
        ram_wdata  = '0;

        case (state_q)
            IDLE:        state_d = IDLE;
            AHB_RD_WAIT: state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        if (ahb_gnt) begin
            ram_en   = 1'b1;
            ram_addr = bp_addr[LOCAL_MEM_SIZE-1:6];
            if (bp_wen) begin
                ram_we     = 1'b1;
                ram_wdata  = {16{bp_wdata}};
                ram_byteen = 64'(bp_strobe) << {bp_addr[5:2], 2'b00};
            end else begin
                state_d = AHB_RD_WAIT;
            end
        end else if (vx_gnt) begin
            ram_en   = 1'b1;
            ram_we   = mem_req_rw;
            ram_addr = mem_req_addr[LW-1:0];
            if (mem_req_rw) begin
                ram_byteen = mem_req_byteen;
                ram_wdata  = mem_req_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            lane_q     <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= vx_gnt & ~mem_req_rw;
            if (vx_gnt & ~mem_req_rw) tag_q <= mem_req_tag;
            if (ahb_gnt & ~bp_wen)    lane_q <= bp_addr[5:2];
            if (~ahb_req | ahb_gnt)
                starve_q <= '0;
            else if (vx_gnt && (starve_q != SW'(MAX_AHB_WAIT)))
                starve_q <= starve_q + 1'b1;
        end
    end

    // ---------------- AHB outputs ----------------
    assign bp_error         = bp_any & ~addr_ok & ~RST;
    assign bp_request_stall = bp_any & addr_ok & ~(ahb_gnt & bp_wen) & (state_q != AHB_RD_WAIT);
    assign bp_rdata         = (state_q == AHB_RD_WAIT) ? ram_rdata[{lane_q, 5'b00000} +: 32] : 32'h0;

    // ---------------- Vortex read-response FIFO ----------------
    assign rsp_push.data = ram_rdata;
    assign rsp_push.tag  = tag_q;
    assign rsp_pop       = mem_rsp_valid & mem_rsp_ready;

    sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .RST      (RST),
        .push_vld (inflight_q),
        .push_dat (rsp_push),
        .pop_vld  (rsp_pop),
        .head_dat (rsp_head),
        .count    (fifo_count)
    );

    // Data/tag are forced to zero when empty so stale storage never leaks out.
    assign mem_rsp_valid = (fifo_count != '0);
    assign mem_rsp_data  = mem_rsp_valid ? rsp_head.data : '0;
    assign mem_rsp_tag   = mem_rsp_valid ? rsp_head.tag  : '0;
endmodule

// File: tb/tb_vortex_mem_arbiter.sv
module tb_vortex_mem_arbiter;
    logic         clk = 1'b0;
    logic         RST;
    logic         mem_req_valid, mem_req_rw;
    logic [63:0]  mem_req_byteen;
    logic [25:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic [55:0]  mem_req_tag;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [55:0]  mem_rsp_tag;
    logic         mem_rsp_ready;
    logic         bp_wen, bp_ren;
    logic [31:0]  bp_addr, bp_wdata;
    logic [3:0]   bp_strobe;
    logic [31:0]  bp_rdata;
    logic         bp_request_stall, bp_error;
    logic         ram_en, ram_we;
    logic [8:0]   ram_addr;
    logic [63:0]  ram_byteen;
    logic [511:0] ram_wdata;
    logic [511:0] ram_rdata = '0;

    int vecs = 0;
    int errs = 0;

    logic [511:0] pat_a = {8{64'h0123_4567_89AB_CDEF}};
    logic [511:0] line1;   // line 1 after the AHB write: bytes 8,9 = EF,BE

    always #5 clk = ~clk;

    vortex_mem_arbiter dut (
        .clk(clk), .RST(RST),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready),
        .bp_wen(bp_wen), .bp_ren(bp_ren), .bp_addr(bp_addr), .bp_wdata(bp_wdata), .bp_strobe(bp_strobe),
        .bp_rdata(bp_rdata), .bp_request_stall(bp_request_stall), .bp_error(bp_error),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_byteen(ram_byteen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port line memory, one-cycle read latency.
    logic [511:0] ram [512];
    initial for (int i = 0; i < 512; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 64; b++)
                    if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    task automatic idle_inputs();
        mem_req_valid = 0; mem_req_rw = 0; mem_req_byteen = '0; mem_req_addr = '0;
        mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 0;
        bp_wen = 0; bp_ren = 0; bp_addr = '0; bp_wdata = '0; bp_strobe = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1;
        repeat (2) @(negedge clk);
        RST = 0;
        #1;
        vecs++; if (mem_req_ready !== 1'b0) begin errs++; $display("FAIL rst_req_ready got %b want 0", mem_req_ready); end
        vecs++; if (mem_rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b want 0", mem_rsp_valid); end
        vecs++; if (mem_rsp_tag !== 56'h0) begin errs++; $display("FAIL rst_rsp_tag got %h want 0", mem_rsp_tag); end
        vecs++; if (ram_en !== 1'b0) begin errs++; $display("FAIL rst_ram_en got %b want 0", ram_en); end
        vecs++; if (bp_request_stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", bp_request_stall); end
        vecs++; if (bp_rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h want 0", bp_rdata); end
    endtask

    task automatic test_vx_write_read();
        @(negedge clk);
        mem_req_valid = 1; mem_req_rw = 1; mem_req_byteen = '1; mem_req_addr = 26'h3C00040; mem_req_data = pat_a;
        #1;
        vecs++; if (mem_req_ready !== 1'b1) begin errs++; $display("FAIL vxw_ready got %b want 1", mem_req_ready); end
        vecs++; if ({ram_en, ram_we} !== 2'b11) begin errs++; $display("FAIL vxw_en_we got %b want 11", {ram_en, ram_we}); end
        vecs++; if (ram_addr !== 9'h040) begin errs++; $display("FAIL vxw_addr got %h want 040", ram_addr); end
        vecs++; if (ram_byteen !== 64'hFFFF_FFFF_FFFF_FFFF) begin errs++; $display("FAIL vxw_byteen got %h want all ones", ram_byteen); end
        vecs++; if (ram_wdata !== pat_a) begin errs++; $display("FAIL vxw_wdata got %h want %h", ram_wdata, pat_a); end
        @(negedge clk);   // read grant, cycle N
        mem_req_rw = 0; mem_req_tag = 56'h15; mem_req_data = '0; mem_req_byteen = '0;
        #1;
        vecs++; if ({mem_req_ready, ram_en, ram_we} !== 3'b110) begin errs++; $display("FAIL vxr_grant got %b want 110", {mem_req_ready, ram_en, ram_we}); end
        @(negedge clk);   // N+1
        mem_req_valid = 0;
        #1;
        vecs++; if (mem_rsp_valid !== 1'b0) begin errs++; $display("FAIL vxr_early_valid got %b want 0", mem_rsp_valid); end
        @(negedge clk);   // N+2
        #1;
        vecs++; if (mem_rsp_valid !== 1'b1) begin errs++; $display("FAIL vxr_valid got %b want 1", mem_rsp_valid); end
        vecs++; if (mem_rsp_data !== pat_a) begin errs++; $display("FAIL vxr_data got %h want %h", mem_rsp_data, pat_a); end
        vecs++; if (mem_rsp_tag !== 56'h15) begin errs++; $display("FAIL vxr_tag got %h want 15", mem_rsp_tag); end
        @(negedge clk);   // held while not ready
        #1;
        vecs++; if ({mem_rsp_valid, mem_rsp_tag} !== {1'b1, 56'h15}) begin errs++; $display("FAIL vxr_hold got %b/%h want 1/15", mem_rsp_valid, mem_rsp_tag); end
        mem_rsp_ready = 1;
        @(negedge clk);
        mem_rsp_ready = 0;
        #1;
        vecs++; if (mem_rsp_valid !== 1'b0) begin errs++; $display("FAIL vxr_popped got %b want 0", mem_rsp_valid); end
    endtask

    task automatic test_ahb_write_read();
        @(negedge clk);
        bp_wen = 1; bp_addr = 32'h48; bp_strobe = 4'h3; bp_wdata = 32'hDEADBEEF;
        #1;
        vecs++; if ({ram_en, ram_we} !== 2'b11) begin errs++; $display("FAIL ahbw_en_we got %b want 11", {ram_en, ram_we}); end
        vecs++; if (ram_addr !== 9'h001) begin errs++; $display("FAIL ahbw_addr got %h want 001", ram_addr); end
        vecs++; if (ram_byteen !== 64'h300) begin errs++; $display("FAIL ahbw_byteen got %h want 300", ram_byteen); end
        vecs++; if (ram_wdata !== {16{32'hDEADBEEF}}) begin errs++; $display("FAIL ahbw_wdata got %h want 16x deadbeef", ram_wdata); end
        vecs++; if ({bp_request_stall, bp_error} !== 2'b00) begin errs++; $display("FAIL ahbw_stall_err got %b want 00", {bp_request_stall, bp_error}); end
        @(negedge clk);
        bp_wen = 0; bp_ren = 1;
        #1;
        vecs++; if ({bp_request_stall, ram_en, ram_we} !== 3'b110) begin errs++; $display("FAIL ahbr_grant got %b want 110", {bp_request_stall, ram_en, ram_we}); end
        vecs++; if (ram_addr !== 9'h001) begin errs++; $display("FAIL ahbr_addr got %h want 001", ram_addr); end
        @(negedge clk);
        #1;
        vecs++; if (bp_request_stall !== 1'b0) begin errs++; $display("FAIL ahbr_wait_stall got %b want 0", bp_request_stall); end
        vecs++; if (bp_rdata !== 32'h0000BEEF) begin errs++; $display("FAIL ahbr_rdata got %h want 0000beef", bp_rdata); end
        bp_ren = 0;
        @(negedge clk);
        #1;
        vecs++; if (bp_rdata !== 32'h0) begin errs++; $display("FAIL ahbr_rdata_idle got %h want 0", bp_rdata); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_req_valid = 1; mem_req_rw = 0; mem_rsp_ready = 0;
            mem_req_tag  = 56'h20 + 56'(accepted);
            mem_req_addr = (accepted == 0) ? 26'h40 : 26'h1;
            #1;
            if (mem_req_ready) accepted++;
        end
        vecs++; if (accepted !== 2) begin errs++; $display("FAIL bp_accepted got %0d want 2", accepted); end
        vecs++; if (mem_req_ready !== 1'b0) begin errs++; $display("FAIL bp_blocked got %b want 0", mem_req_ready); end
        @(negedge clk);   // D0: FIFO full, pop first entry
        mem_rsp_ready = 1; mem_req_tag = 56'h30; mem_req_addr = 26'h40;
        #1;
        vecs++; if (mem_req_ready !== 1'b0) begin errs++; $display("FAIL bp_d0_ready got %b want 0", mem_req_ready); end
        vecs++; if ({mem_rsp_valid, mem_rsp_tag} !== {1'b1, 56'h20}) begin errs++; $display("FAIL bp_d0_rsp got %b/%h want 1/20", mem_rsp_valid, mem_rsp_tag); end
        vecs++; if (mem_rsp_data !== pat_a) begin errs++; $display("FAIL bp_d0_data got %h want %h", mem_rsp_data, pat_a); end
        @(negedge clk);   // D1: one slot free, requests resume
        #1;
        vecs++; if (mem_req_ready !== 1'b1) begin errs++; $display("FAIL bp_d1_resume got %b want 1", mem_req_ready); end
        vecs++; if ({mem_rsp_valid, mem_rsp_tag} !== {1'b1, 56'h21}) begin errs++; $display("FAIL bp_d1_rsp got %b/%h want 1/21", mem_rsp_valid, mem_rsp_tag); end
        vecs++; if (mem_rsp_data !== line1) begin errs++; $display("FAIL bp_d1_data got %h want %h", mem_rsp_data, line1); end
        @(negedge clk);   // D2
        mem_req_valid = 0;
        #1;
        vecs++; if (mem_rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_d2_empty got %b want 0", mem_rsp_valid); end
        @(negedge clk);   // D3
        #1;
        vecs++; if ({mem_rsp_valid, mem_rsp_tag} !== {1'b1, 56'h30}) begin errs++; $display("FAIL bp_d3_rsp got %b/%h want 1/30", mem_rsp_valid, mem_rsp_tag); end
        @(negedge clk);
        mem_rsp_ready = 0;
        #1;
        vecs++; if (mem_rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_drained got %b want 0", mem_rsp_valid); end
    endtask

    task automatic test_starvation();
        int vx_grants = 0;
        int ahb_cycle = -1;
        for (int i = 0; i < 10 && ahb_cycle < 0; i++) begin
            @(negedge clk);
            mem_req_valid = 1; mem_req_rw = 1; mem_req_addr = 26'h5; mem_req_byteen = '1; mem_req_data = pat_a;
            bp_ren = 1; bp_addr = 32'h48;
            #1;
            if (mem_req_ready) vx_grants++;
            if (bp_request_stall && ram_en && !ram_we) ahb_cycle = i;
        end
        vecs++; if (ahb_cycle !== 4) begin errs++; $display("FAIL starve_ahb_cycle got %0d want 4", ahb_cycle); end
        vecs++; if (vx_grants !== 4) begin errs++; $display("FAIL starve_vx_grants got %0d want 4", vx_grants); end
        @(negedge clk);   // AHB_RD_WAIT: data out, Vortex may go
        #1;
        vecs++; if (bp_rdata !== 32'h0000BEEF) begin errs++; $display("FAIL starve_rdata got %h want 0000beef", bp_rdata); end
        vecs++; if (mem_req_ready !== 1'b1) begin errs++; $display("FAIL starve_vx_after got %b want 1", mem_req_ready); end
        bp_ren = 0;
        @(negedge clk);   // fresh AHB request: counter cleared, Vortex wins again
        bp_ren = 1;
        #1;
        vecs++; if ({mem_req_ready, bp_request_stall} !== 2'b11) begin errs++; $display("FAIL starve_cleared got %b want 11", {mem_req_ready, bp_request_stall}); end
        bp_ren = 0; mem_req_valid = 0;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_addr_error();
        @(negedge clk);
        bp_wen = 1; bp_addr = 32'h0001_0000; bp_wdata = 32'h1234_5678; bp_strobe = 4'hF;
        #1;
        vecs++; if (bp_error !== 1'b1) begin errs++; $display("FAIL err_flag got %b want 1", bp_error); end
        vecs++; if (bp_request_stall !== 1'b0) begin errs++; $display("FAIL err_stall got %b want 0", bp_request_stall); end
        vecs++; if (ram_en !== 1'b0) begin errs++; $display("FAIL err_ram_en got %b want 0", ram_en); end
        @(negedge clk);
        bp_wen = 0;
        #1;
        vecs++; if (bp_error !== 1'b0) begin errs++; $display("FAIL err_clear got %b want 0", bp_error); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_req_valid = 1; mem_req_rw = 0; mem_req_addr = 26'h40; mem_req_tag = 56'h3A; mem_rsp_ready = 0;
        #1;
        vecs++; if (mem_req_ready !== 1'b1) begin errs++; $display("FAIL rmid_vx_grant got %b want 1", mem_req_ready); end
        @(negedge clk);
        mem_req_valid = 0; bp_ren = 1; bp_addr = 32'h48;
        #1;
        vecs++; if ({bp_request_stall, ram_en} !== 2'b11) begin errs++; $display("FAIL rmid_ahb_grant got %b want 11", {bp_request_stall, ram_en}); end
        @(negedge clk);   // AHB_RD_WAIT with FIFO occupied
        #1;
        vecs++; if ({mem_rsp_valid, bp_rdata} !== {1'b1, 32'h0000BEEF}) begin errs++; $display("FAIL rmid_pre got %b/%h want 1/0000beef", mem_rsp_valid, bp_rdata); end
        RST = 1;
        idle_inputs();
        @(negedge clk);
        RST = 0;
        #1;
        vecs++; if (mem_rsp_valid !== 1'b0) begin errs++; $display("FAIL rmid_rsp_valid got %b want 0", mem_rsp_valid); end
        vecs++; if (bp_rdata !== 32'h0) begin errs++; $display("FAIL rmid_rdata got %h want 0", bp_rdata); end
        vecs++; if ({ram_en, bp_request_stall, bp_error, mem_req_ready} !== 4'b0000) begin errs++; $display("FAIL rmid_outs got %b want 0000", {ram_en, bp_request_stall, bp_error, mem_req_ready}); end
        @(negedge clk);
        #1;
        vecs++; if (mem_rsp_valid !== 1'b0) begin errs++; $display("FAIL rmid_no_late_rsp got %b want 0", mem_rsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        line1 = '0;
        line1[79:64] = 16'hBEEF;
        test_reset();
        test_vx_write_read();
        test_ahb_write_read();
        test_backpressure();
        test_starvation();
        test_addr_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/vortex_mem_arbiter.md
Name: vortex_mem_arbiter

Overview:
Shares the single port of the on-chip 512-bit-line GPU local memory between the Vortex memory interface and the AHB generic bus peripheral interface. Grants one requester per cycle, with Vortex priority and a bounded AHB starvation limit. Converts AHB word accesses into masked 512-bit line accesses. Buffers Vortex read responses in a small FIFO so that mem_rsp_ready backpressure is honoured.

Parameters:
LOCAL_MEM_SIZE, 15, log2 of memory bytes; line index is LOCAL_MEM_SIZE-6 bits
VX_ADDR_WIDTH, 26, Vortex line address width
VX_TAG_WIDTH, 56, Vortex request tag width
RSP_DEPTH, 2, Vortex read-response FIFO depth (power of 2, >=2)
MAX_AHB_WAIT, 4, consecutive denied cycles before AHB is forced to win

Ports:
clk  in  1  clock
RST  in  1  reset, synchronous, active-high
mem_req_valid  in  1  Vortex request valid
mem_req_rw  in  1  1=write, 0=read
mem_req_byteen  in  64  Vortex byte enables
mem_req_addr  in  VX_ADDR_WIDTH  Vortex line address
mem_req_data  in  512  Vortex write data
mem_req_tag  in  VX_TAG_WIDTH  Vortex tag
mem_req_ready  out  1  Vortex request accepted this cycle
mem_rsp_valid  out  1  Vortex read response valid
mem_rsp_data  out  512  response line
mem_rsp_tag  out  VX_TAG_WIDTH  response tag
mem_rsp_ready  in  1  Vortex consumes response
bp_wen, bp_ren  in  1 each  AHB write/read request (held while stalled)
bp_addr  in  32  AHB byte offset address
bp_wdata  in  32  AHB write word
bp_strobe  in  4  AHB byte strobes
bp_rdata  out  32  AHB read word
bp_request_stall  out  1  AHB wait state
bp_error  out  1  AHB address out of range
ram_en  out  1  memory access this cycle
ram_we  out  1  memory write
ram_addr  out  LOCAL_MEM_SIZE-6  line index
ram_byteen  out  64  byte mask for writes
ram_wdata  out  512  write line
ram_rdata  in  512  read line, valid the cycle after ram_en & ~ram_we

Behaviour:
- Reset (RST high at a clk edge): FSM=IDLE, FIFO empty, in-flight flag 0, starvation counter 0. All outputs 0 except bp_request_stall, which follows the combinational rule below.
- Request qualification: ahb_req = (bp_wen|bp_ren) & addr_ok & state!=AHB_RD_WAIT. addr_ok = bp_addr[31:LOCAL_MEM_SIZE]==0.
- Out-of-range AHB address: bp_error=1, bp_request_stall=0, no RAM access, FSM unchanged.
- vx_ok = mem_req_valid & (mem_req_rw | fifo_count+inflight < RSP_DEPTH).
- Grant, once per cycle:
  - AHB wins if ahb_req & (~vx_ok | starve_cnt==MAX_AHB_WAIT).
  - Otherwise Vortex wins if vx_ok.
- mem_req_ready = Vortex granted (combinational). A request transfers on mem_req_valid & mem_req_ready.
- starve_cnt: +1 when ahb_req & Vortex granted. Cleared on AHB grant or when ~ahb_req. Saturates at MAX_AHB_WAIT.
- Vortex write grant: ram_en=1, ram_we=1, ram_addr=mem_req_addr[LOCAL_MEM_SIZE-7:0], ram_byteen=mem_req_byteen, ram_wdata=mem_req_data. No response.
- Vortex read grant (cycle N):
  - ram_en=1, ram_we=0; set inflight and register the tag.
  - N+1: push {ram_rdata, tag} into the FIFO; clear inflight.
  - mem_rsp_valid is 1 from N+2 when the FIFO was empty (FIFO head is registered).
- FIFO pop on mem_rsp_valid & mem_rsp_ready. mem_rsp_data/tag hold while valid & ~ready. Simultaneous push and pop with the FIFO full is impossible by the vx_ok rule; push+pop otherwise keeps the count.
- AHB write grant:
  - ram_we=1, ram_addr=bp_addr[LOCAL_MEM_SIZE-1:6], ram_wdata={16{bp_wdata}}.
  - ram_byteen = bp_strobe << (4*bp_addr[5:2]).
  - bp_request_stall=0 in the grant cycle.
- AHB read grant (cycle N):
  - ram read issued, bp_request_stall=1; register lane=bp_addr[5:2]; FSM IDLE->AHB_RD_WAIT.
  - N+1: bp_rdata = ram_rdata[32*lane+:32], bp_request_stall=0, FSM->IDLE. Vortex may be granted in N+1.
- bp_request_stall = (bp_wen|bp_ren) & addr_ok & ~(AHB write granted) & ~(state==AHB_RD_WAIT). bp_rdata=0 outside AHB_RD_WAIT.
- Reset mid-operation: the in-flight read is discarded, FIFO contents are lost, and no response is emitted after reset.

Test Plan:
- Vortex write addr 0x3C00040 byteen=all-ones data=pattern A, then read with tag 0x15 -> ram write cycle N; read response data=A, tag=0x15, mem_rsp_valid at read-grant+2.
- AHB write addr 0x48 strobe=0x3 wdata=0xDEADBEEF -> ram_addr=1, ram_byteen=0x3<<8, stall 0. AHB read 0x48 -> stall 1 cycle, then bp_rdata=0xDEADBEEF masked per stored bytes.
- Vortex read each cycle with mem_rsp_ready=0 -> exactly 2 accepted (RSP_DEPTH=2), then mem_req_ready=0. Assert ready -> responses drain in order, and requests resume.
- Vortex valid every cycle plus held AHB read -> AHB granted after exactly 4 Vortex grants; counter clears.
- bp_addr=0x00010000 with wen -> bp_error=1, stall=0, ram_en=0.
- RST asserted during AHB_RD_WAIT with FIFO occupied -> next cycle all outputs 0, FIFO empty, FSM IDLE.
